// File: rtl/regfile_scoreboard.sv
// Integer register file: 2 read ports, 2 prioritised write ports, busy scoreboard, sweep-clear engine.
// Latency: reads and busy flags are combinational; writes and scoreboard updates commit on the next rising edge.
// Backpressure: none on ports; clr_busy stalls the pipeline for NREG cycles while the sweep runs.
//
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   rs1/rs2 -> rd1/rd2           read addresses and data (0 while sweeping)
//   rs1_busy/rs2_busy            scoreboard flags for the read addresses
//   wb0_* / wb1_*                writeback ports, wb1 is the younger instruction and wins conflicts
//   iss_en/iss_rd                marks the issuing instruction's destination busy
//   flush                        clears every busy bit
//   clr_req -> clr_busy          starts the register sweep / sweep in progress
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  localparam int AW      = $clog2(NREG),
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wb0_en,
  input  logic [AW-1:0]   wb0_addr,
  input  logic [XLEN-1:0] wb0_data,
  input  logic            wb1_en,
  input  logic [AW-1:0]   wb1_addr,
  input  logic [XLEN-1:0] wb1_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush,
  input  logic            clr_req,
  output logic            clr_busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;

  logic sweeping;
  assign sweeping = (state_q == ST_SWEEP);
  assign clr_busy = sweeping;

  // Next-state for array, scoreboard and sweep engine.
  always_comb begin
    regs_d  = regs_q;
    busy_d  = busy_q;
    state_d = state_q;
    idx_d   = idx_q;
    if (!sweeping) begin
      // Port 1 assigned last so the younger instruction wins an address clash.
      if (wb0_en) regs_d[wb0_addr] = wb0_data;
      if (wb1_en) regs_d[wb1_addr] = wb1_data;
      if (clr_req) begin
        state_d = ST_SWEEP;
        idx_d   = '0;
        busy_d  = '0;
      end else if (flush) begin
        busy_d = '0;
      end else begin
        if (wb0_en) busy_d[wb0_addr] = 1'b0;
        if (wb1_en) busy_d[wb1_addr] = 1'b0;
        // Issue applied after writeback clears: a new producer keeps the register busy.
        if (iss_en) busy_d[iss_rd] = 1'b1;
      end
    end else begin
      regs_d[idx_q] = '0;
      if (idx_q == AW'(NREG - 1)) begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + AW'(1);
      end
    end
    if (ZERO_REG != 0) begin
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q  <= '0;
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      busy_q  <= busy_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Bypass hits; writes are ignored while sweeping so forwarding is suppressed too.
  logic byp_on;
  logic h1_wb0, h1_wb1, h2_wb0, h2_wb1;
  assign byp_on = (BYPASS != 0) && !sweeping;
  assign h1_wb0 = byp_on && wb0_en && (wb0_addr == rs1);
  assign h1_wb1 = byp_on && wb1_en && (wb1_addr == rs1);
  assign h2_wb0 = byp_on && wb0_en && (wb0_addr == rs2);
  assign h2_wb1 = byp_on && wb1_en && (wb1_addr == rs2);

  always_comb begin
    rd1 = regs_q[rs1];
    if (h1_wb1)      rd1 = wb1_data;
    else if (h1_wb0) rd1 = wb0_data;
    if (sweeping || ((ZERO_REG != 0) && (rs1 == '0))) rd1 = '0;
  end

  always_comb begin
    rd2 = regs_q[rs2];
    if (h2_wb1)      rd2 = wb2_sel_dummy(wb1_data);
    else if (h2_wb0) rd2 = wb0_data;
    if (sweeping || ((ZERO_REG != 0) && (rs2 == '0))) rd2 = '0;
  end

  function automatic logic [XLEN-1:0] wb2_sel_dummy(input logic [XLEN-1:0] d);
    return d;
  endfunction

  // A forwarded operand is not a hazard, so the busy flag is masked on a bypass hit.
  assign rs1_busy = !sweeping && busy_q[rs1] && !(h1_wb0 || h1_wb1);
  assign rs2_busy = !sweeping && busy_q[rs2] && !(h2_wb0 || h2_wb1);

endmodule
